// File: rtl/line_window_gen_pkg.sv
// Shared helpers for the line window generator: log2 ceiling and parameter range checks.
package line_window_gen_pkg;

  localparam int unsigned LP_K_MIN = 2;
  localparam int unsigned LP_K_MAX = 7;

  // Smallest n with 2**n >= v (0 for v <= 1).
  function automatic int unsigned f_clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  function automatic bit f_k_legal(input int unsigned k);
    return (k >= LP_K_MIN) && (k <= LP_K_MAX);
  endfunction

  function automatic bit f_stride_legal(input int unsigned s, input int unsigned k);
    return (s >= 1) && (s <= k);
  endfunction

endpackage

// File: rtl/line_window_gen_line_ram.sv
// Single-port line buffer: combinational read at the addressed entry, registered write.
// A read and a write to the same address in one cycle returns the old contents.
module line_ram
  import line_window_gen_pkg::*;
#(
  parameter int unsigned P_DW    = 8,
  parameter int unsigned P_DEPTH = 150
) (
  input  logic                         i_clk,
  input  logic                         i_we,
  input  logic [f_clog2(P_DEPTH)-1:0]  i_addr,
  input  logic [P_DW-1:0]              i_wdata,
  output logic [P_DW-1:0]              o_rdata
);

  logic [P_DW-1:0] r_mem [P_DEPTH];

  assign o_rdata = r_mem[i_addr];

  // Registered write; contents are intentionally not reset.
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
  end

endmodule

// File: rtl/line_window_gen.sv
// Sliding KxK window generator over a raster pixel stream with configurable stride.
module line_window_gen
  import line_window_gen_pkg::*;
#(
  parameter int unsigned P_DW     = 8,
  parameter int unsigned P_K      = 3,
  parameter int unsigned P_IMG_W  = 150,
  parameter int unsigned P_IMG_H  = 150,
  parameter int unsigned P_STRIDE = 1
) (
  input  logic                          jct_i_clk,
  input  logic                          jct_i_rst_n,
  input  logic                          jct_i_c_clr,
  input  logic [P_DW-1:0]               jct_i_d_dataflow,
  input  logic                          jct_i_c_valid,
  output logic [P_K*P_K*P_DW-1:0]       jct_o_d_window,
  output logic                          jct_o_c_valid,
  output logic                          jct_o_c_last,
  output logic [f_clog2(P_IMG_H)-1:0]   jct_o_d_row,
  output logic [f_clog2(P_IMG_W)-1:0]   jct_o_d_col
);

  localparam int unsigned LP_RW = f_clog2(P_IMG_H);
  localparam int unsigned LP_CW = f_clog2(P_IMG_W);
  localparam int unsigned LP_PW = f_clog2(P_K + 1);

  localparam logic [LP_CW-1:0] LP_COL_MAX  = LP_CW'(P_IMG_W - 1);
  localparam logic [LP_RW-1:0] LP_ROW_MAX  = LP_RW'(P_IMG_H - 1);
  localparam logic [LP_CW-1:0] LP_COL_K    = LP_CW'(P_K - 1);
  localparam logic [LP_RW-1:0] LP_ROW_K    = LP_RW'(P_K - 1);
  localparam logic [LP_PW-1:0] LP_PH_MAX   = LP_PW'(P_STRIDE - 1);
  // Position of the final window that lands on the stride grid.
  localparam logic [LP_RW-1:0] LP_ROW_LAST = LP_RW'(P_K - 1 + ((P_IMG_H - P_K) / P_STRIDE) * P_STRIDE);
  localparam logic [LP_CW-1:0] LP_COL_LAST = LP_CW'(P_K - 1 + ((P_IMG_W - P_K) / P_STRIDE) * P_STRIDE);

  if (!f_k_legal(P_K)) begin : g_bad_k
    $error("line_window_gen: P_K must be in 2..7");
  end
  if (!f_stride_legal(P_STRIDE, P_K)) begin : g_bad_stride
    $error("line_window_gen: P_STRIDE must be in 1..P_K");
  end
  if ((P_IMG_W < P_K) || (P_IMG_H < P_K)) begin : g_bad_img
    $error("line_window_gen: image dimensions must be >= P_K");
  end

  logic [LP_CW-1:0] r_col;
  logic [LP_RW-1:0] r_row;
  logic [LP_PW-1:0] r_cph;
  logic [LP_PW-1:0] r_rph;

  logic w_accept;
  logic w_col_wrap;
  logic w_row_wrap;
  logic w_fire;
  logic w_last;

  logic [P_DW-1:0] w_lb_in  [P_K-1];
  logic [P_DW-1:0] w_lb_out [P_K-1];
  logic [P_DW-1:0] w_col_in [P_K];
  logic [P_DW-1:0] r_win    [P_K][P_K];
  logic [P_DW-1:0] w_win_nxt[P_K][P_K];
  logic [P_K*P_K*P_DW-1:0] w_win_flat;

  assign w_accept   = jct_i_c_valid & ~jct_i_c_clr;
  assign w_col_wrap = (r_col == LP_COL_MAX);
  assign w_row_wrap = (r_row == LP_ROW_MAX);
  assign w_fire     = w_accept && (r_row >= LP_ROW_K) && (r_col >= LP_COL_K) &&
                      (r_rph == '0) && (r_cph == '0);
  assign w_last     = (r_row == LP_ROW_LAST) && (r_col == LP_COL_LAST);

  // Line buffer chain: buffer 0 takes the pixel, buffer g takes buffer g-1's old entry.
  // Incoming column is ordered oldest line at row 0, current pixel at row P_K-1.
  assign w_col_in[P_K-1] = jct_i_d_dataflow;
  for (genvar g = 0; g < P_K - 1; g++) begin : g_lb
    if (g == 0) begin : g_first
      assign w_lb_in[g] = jct_i_d_dataflow;
    end else begin : g_chain
      assign w_lb_in[g] = w_lb_out[g-1];
    end
    assign w_col_in[g] = w_lb_out[P_K-2-g];

    line_ram #(
      .P_DW    (P_DW),
      .P_DEPTH (P_IMG_W)
    ) u_line_ram (
      .i_clk   (jct_i_clk),
      .i_we    (w_accept),
      .i_addr  (r_col),
      .i_wdata (w_lb_in[g]),
      .o_rdata (w_lb_out[g])
    );
  end

  // Next shift-array contents: each row moves one column left, new column enters on the right.
  always_comb begin
    for (int unsigned r = 0; r < P_K; r++) begin
      for (int unsigned c = 0; c < P_K - 1; c++) begin
        w_win_nxt[r][c] = r_win[r][c+1];
      end
      w_win_nxt[r][P_K-1] = w_col_in[r];
    end
  end

  // Flatten the next window into the output bus layout.
  always_comb begin
    w_win_flat = '0;
    for (int unsigned r = 0; r < P_K; r++) begin
      for (int unsigned c = 0; c < P_K; c++) begin
        w_win_flat[(r*P_K+c)*P_DW +: P_DW] = w_win_nxt[r][c];
      end
    end
  end

  // Raster counters plus stride phases; a phase is pinned to 0 until its counter reaches K-1,
  // so phase 0 at K-1+n*S marks the stride grid without any division.
  always_ff @(posedge jct_i_clk or negedge jct_i_rst_n) begin
    if (!jct_i_rst_n) begin
      r_col <= '0;
      r_row <= '0;
      r_cph <= '0;
      r_rph <= '0;
    end else if (jct_i_c_clr) begin
      r_col <= '0;
      r_row <= '0;
      r_cph <= '0;
      r_rph <= '0;
    end else if (w_accept) begin
      if (w_col_wrap) begin
        r_col <= '0;
        r_cph <= '0;
        if (w_row_wrap) begin
          r_row <= '0;
          r_rph <= '0;
        end else begin
          r_row <= r_row + 1'b1;
          if (r_row < LP_ROW_K)        r_rph <= '0;
          else if (r_rph == LP_PH_MAX) r_rph <= '0;
          else                         r_rph <= r_rph + 1'b1;
        end
      end else begin
        r_col <= r_col + 1'b1;
        if (r_col < LP_COL_K)        r_cph <= '0;
        else if (r_cph == LP_PH_MAX) r_cph <= '0;
        else                         r_cph <= r_cph + 1'b1;
      end
    end
  end

  // Shift array advances only on accepted pixels.
  always_ff @(posedge jct_i_clk or negedge jct_i_rst_n) begin
    if (!jct_i_rst_n) begin
      r_win <= '{default: '0};
    end else if (w_accept) begin
      r_win <= w_win_nxt;
    end
  end

  // Registered window outputs; data and position hold between emitted windows.
  always_ff @(posedge jct_i_clk or negedge jct_i_rst_n) begin
    if (!jct_i_rst_n) begin
      jct_o_c_valid  <= 1'b0;
      jct_o_c_last   <= 1'b0;
      jct_o_d_window <= '0;
      jct_o_d_row    <= '0;
      jct_o_d_col    <= '0;
    end else begin
      jct_o_c_valid <= w_fire;
      jct_o_c_last  <= w_fire & w_last;
      if (w_fire) begin
        jct_o_d_window <= w_win_flat;
        jct_o_d_row    <= r_row - LP_ROW_K;
        jct_o_d_col    <= r_col - LP_COL_K;
      end
    end
  end

endmodule

// File: tb/tb_line_window_gen.sv
// Directed bench: K=3 8x8 at stride 1 and 2 sharing one stream, plus K=5 7x6.
module tb_line_window_gen;

  logic        clk;
  logic        rst_n;
  logic        ab_clr;
  logic        ab_vld;
  logic [7:0]  ab_din;
  logic        c_clr;
  logic        c_vld;
  logic [7:0]  c_din;

  logic [71:0]  a_win;
  logic         a_v;
  logic         a_l;
  logic [2:0]   a_row;
  logic [2:0]   a_col;
  logic [71:0]  b_win;
  logic         b_v;
  logic         b_l;
  logic [2:0]   b_row;
  logic [2:0]   b_col;
  logic [199:0] c_win;
  logic         c_v;
  logic         c_l;
  logic [2:0]   c_row;
  logic [2:0]   c_col;

  int checks;
  int failures;

  line_window_gen #(.P_DW(8), .P_K(3), .P_IMG_W(8), .P_IMG_H(8), .P_STRIDE(1)) u_dut_a (
    .jct_i_clk(clk), .jct_i_rst_n(rst_n), .jct_i_c_clr(ab_clr),
    .jct_i_d_dataflow(ab_din), .jct_i_c_valid(ab_vld),
    .jct_o_d_window(a_win), .jct_o_c_valid(a_v), .jct_o_c_last(a_l),
    .jct_o_d_row(a_row), .jct_o_d_col(a_col)
  );

  line_window_gen #(.P_DW(8), .P_K(3), .P_IMG_W(8), .P_IMG_H(8), .P_STRIDE(2)) u_dut_b (
    .jct_i_clk(clk), .jct_i_rst_n(rst_n), .jct_i_c_clr(ab_clr),
    .jct_i_d_dataflow(ab_din), .jct_i_c_valid(ab_vld),
    .jct_o_d_window(b_win), .jct_o_c_valid(b_v), .jct_o_c_last(b_l),
    .jct_o_d_row(b_row), .jct_o_d_col(b_col)
  );

  line_window_gen #(.P_DW(8), .P_K(5), .P_IMG_W(7), .P_IMG_H(6), .P_STRIDE(1)) u_dut_c (
    .jct_i_clk(clk), .jct_i_rst_n(rst_n), .jct_i_c_clr(c_clr),
    .jct_i_d_dataflow(c_din), .jct_i_c_valid(c_vld),
    .jct_o_d_window(c_win), .jct_o_c_valid(c_v), .jct_o_c_last(c_l),
    .jct_o_d_row(c_row), .jct_o_d_col(c_col)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected K=3 window on an 8-wide image whose pixel value is (index + off) mod 256.
  function automatic logic [71:0] exp_a(input int orow, input int ocol, input int off);
    logic [71:0] w;
    w = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        w[(r*3+c)*8 +: 8] = 8'((orow + r) * 8 + ocol + c + off);
    return w;
  endfunction

  // Expected K=5 window on a 7-wide image whose pixel value is its raster index.
  function automatic logic [199:0] exp_c(input int orow, input int ocol);
    logic [199:0] w;
    w = '0;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        w[(r*5+c)*8 +: 8] = 8'((orow + r) * 7 + ocol + c);
    return w;
  endfunction

  task automatic step_ab(input logic v, input logic c, input logic [7:0] d);
    ab_vld = v;
    ab_clr = c;
    ab_din = d;
    @(posedge clk);
    #1;
  endtask

  // One full 8x8 frame into A and B with optional idle gaps, checked cycle by cycle.
  task automatic run_frame_ab(input int gap_pct, input int off);
    int na, nb, pr, pc, ng;
    logic ea, eb;
    logic [71:0] held_a, held_b;
    na = 0;
    nb = 0;
    for (int p = 0; p < 64; p++) begin
      pr = p / 8;
      pc = p % 8;
      ng = 0;
      while (gap_pct > 0 && ng < 4 && $urandom_range(99) < gap_pct) begin
        held_a = a_win;
        held_b = b_win;
        step_ab(1'b0, 1'b0, 8'($urandom));
        checks++;
        if (a_v !== 1'b0 || b_v !== 1'b0 || a_l !== 1'b0 || b_l !== 1'b0) begin
          failures++;
          $display("FAIL idle_valid p=%0d a_v=%b b_v=%b a_l=%b b_l=%b required 0", p, a_v, b_v, a_l, b_l);
        end
        checks++;
        if (a_win !== held_a || b_win !== held_b) begin
          failures++;
          $display("FAIL idle_hold p=%0d a_win=%h required %h b_win=%h required %h", p, a_win, held_a, b_win, held_b);
        end
        ng++;
      end
      step_ab(1'b1, 1'b0, 8'(p + off));
      ea = (pr >= 2) && (pc >= 2);
      eb = ea && ((pr - 2) % 2 == 0) && ((pc - 2) % 2 == 0);
      checks++;
      if (a_v !== ea) begin
        failures++;
        $display("FAIL a_valid p=%0d got %b required %b", p, a_v, ea);
      end
      if (ea) begin
        na++;
        checks++;
        if (a_win !== exp_a(pr - 2, pc - 2, off) || a_row !== 3'(pr - 2) || a_col !== 3'(pc - 2)) begin
          failures++;
          $display("FAIL a_window p=%0d got %h r%0d c%0d required %h r%0d c%0d",
                   p, a_win, a_row, a_col, exp_a(pr - 2, pc - 2, off), pr - 2, pc - 2);
        end
      end
      checks++;
      if (a_l !== (ea && pr == 7 && pc == 7)) begin
        failures++;
        $display("FAIL a_last p=%0d got %b required %b", p, a_l, (ea && pr == 7 && pc == 7));
      end
      checks++;
      if (b_v !== eb) begin
        failures++;
        $display("FAIL b_valid p=%0d got %b required %b", p, b_v, eb);
      end
      if (eb) begin
        nb++;
        checks++;
        if (b_win !== exp_a(pr - 2, pc - 2, off) || b_row !== 3'(pr - 2) || b_col !== 3'(pc - 2)) begin
          failures++;
          $display("FAIL b_window p=%0d got %h r%0d c%0d required %h r%0d c%0d",
                   p, b_win, b_row, b_col, exp_a(pr - 2, pc - 2, off), pr - 2, pc - 2);
        end
      end
      checks++;
      if (b_l !== (eb && pr == 6 && pc == 6)) begin
        failures++;
        $display("FAIL b_last p=%0d got %b required %b", p, b_l, (eb && pr == 6 && pc == 6));
      end
    end
    ab_vld = 1'b0;
    checks++;
    if (na != 36) begin
      failures++;
      $display("FAIL a_count got %0d required 36", na);
    end
    checks++;
    if (nb != 9) begin
      failures++;
      $display("FAIL b_count got %0d required 9", nb);
    end
  endtask

  task automatic test_reset;
    rst_n  = 1'b0;
    ab_vld = 1'b0;
    ab_clr = 1'b0;
    ab_din = '0;
    c_vld  = 1'b0;
    c_clr  = 1'b0;
    c_din  = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (a_v !== 1'b0 || a_l !== 1'b0 || a_row !== 3'd0 || a_col !== 3'd0 || a_win !== '0) begin
      failures++;
      $display("FAIL reset_a v=%b l=%b r=%0d c=%0d win=%h required all 0", a_v, a_l, a_row, a_col, a_win);
    end
    checks++;
    if (b_v !== 1'b0 || b_win !== '0 || c_v !== 1'b0 || c_l !== 1'b0 || c_win !== '0) begin
      failures++;
      $display("FAIL reset_bc b_v=%b b_win=%h c_v=%b c_win=%h required all 0", b_v, b_win, c_v, c_win);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_full_frame;
    run_frame_ab(0, 0);
  endtask

  task automatic test_gaps;
    run_frame_ab(50, 0);
  endtask

  task automatic test_clear;
    for (int p = 0; p < 30; p++) step_ab(1'b1, 1'b0, 8'(p));
    step_ab(1'b1, 1'b1, 8'd30);
    checks++;
    if (a_v !== 1'b0 || a_l !== 1'b0 || b_v !== 1'b0) begin
      failures++;
      $display("FAIL clear_valid a_v=%b a_l=%b b_v=%b required 0", a_v, a_l, b_v);
    end
    step_ab(1'b0, 1'b0, 8'd0);
    run_frame_ab(0, 64);
  endtask

  task automatic test_reset_mid;
    for (int p = 0; p < 28; p++) step_ab(1'b1, 1'b0, 8'(p));
    checks++;
    if (a_v !== 1'b1 || a_row !== 3'd1 || a_col !== 3'd1) begin
      failures++;
      $display("FAIL pre_reset_window v=%b r=%0d c=%0d required 1 r1 c1", a_v, a_row, a_col);
    end
    ab_vld = 1'b0;
    rst_n  = 1'b0;
    #1;
    checks++;
    if (a_v !== 1'b0 || a_l !== 1'b0 || a_row !== 3'd0 || a_col !== 3'd0 || a_win !== '0) begin
      failures++;
      $display("FAIL async_reset v=%b l=%b r=%0d c=%0d win=%h required all 0", a_v, a_l, a_row, a_col, a_win);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_frame_ab(0, 128);
  endtask

  task automatic test_k5;
    int n, pr, pc;
    logic e;
    n = 0;
    for (int p = 0; p < 42; p++) begin
      pr = p / 7;
      pc = p % 7;
      c_vld = 1'b1;
      c_din = 8'(p);
      @(posedge clk);
      #1;
      e = (pr >= 4) && (pc >= 4);
      checks++;
      if (c_v !== e) begin
        failures++;
        $display("FAIL k5_valid p=%0d got %b required %b", p, c_v, e);
      end
      if (e) begin
        n++;
        checks++;
        if (c_win !== exp_c(pr - 4, pc - 4) || c_row !== 3'(pr - 4) || c_col !== 3'(pc - 4)) begin
          failures++;
          $display("FAIL k5_window p=%0d got %h r%0d c%0d required %h r%0d c%0d",
                   p, c_win, c_row, c_col, exp_c(pr - 4, pc - 4), pr - 4, pc - 4);
        end
      end
      checks++;
      if (c_l !== (e && pr == 5 && pc == 6)) begin
        failures++;
        $display("FAIL k5_last p=%0d got %b required %b", p, c_l, (e && pr == 5 && pc == 6));
      end
    end
    c_vld = 1'b0;
    checks++;
    if (n != 6) begin
      failures++;
      $display("FAIL k5_count got %0d required 6", n);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_full_frame();
    test_gaps();
    test_clear();
    test_reset_mid();
    test_k5();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
